// File: rtl/seg_scan_ctrl.sv
// seg_scan_ctrl: multiplexed 4-digit 7-segment scan controller with frame-aligned value updates
// Ports: clk, reset (async, active-high); value/load capture a new 16-bit display value;
//        loaded pulses one cycle after a commit; rom_addr/rom_data talk to an external
//        synchronous pattern ROM; seg passes rom_data through; an is the active-low digit enable.
// Optional feature: define SEG_SCAN_LZ_BLANK_EN to blank leading-zero digits.
module seg_scan_ctrl #(
  parameter int CLK_DIV = 50000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] value,
  input  logic        load,
  output logic        loaded,
  output logic [3:0]  rom_addr,
  input  logic [6:0]  rom_data,
  output logic [6:0]  seg,
  output logic [3:0]  an
);
  logic [15:0] tick_cnt_q, tick_cnt_d;
  logic [1:0]  digit_q, digit_d;
  logic [15:0] shadow_q, shadow_d;
  logic [15:0] pending_q, pending_d;
  logic        pend_valid_q, pend_valid_d;
  logic        loaded_q, loaded_d;
  logic [3:0]  an_q, an_d;
  logic        tick, frame_start, lz_blank;
  logic [15:0] shifted;
  always_comb begin
    tick         = tick_cnt_q == 16'(CLK_DIV - 1);
    frame_start  = tick && digit_q == 2'd3;
    tick_cnt_d   = tick ? 16'd0 : tick_cnt_q + 16'd1;
    digit_d      = tick ? digit_q + 2'd1 : digit_q;
    // A load landing on the frame-start tick wins over any older pending value.
    shadow_d     = frame_start ? (load ? value : pend_valid_q ? pending_q : shadow_q) : shadow_q;
    pending_d    = load && !frame_start ? value : pending_q;
    pend_valid_d = frame_start ? 1'b0 : load ? 1'b1 : pend_valid_q;
    loaded_d     = frame_start && (load || pend_valid_q);
    shifted      = shadow_q >> {digit_q, 2'b00};
    rom_addr     = shifted[3:0];
`ifdef SEG_SCAN_LZ_BLANK_EN
    // Digit k>0 is dark when it and every more significant nibble are zero.
    lz_blank     = digit_q != 2'd0 && shifted == 16'd0;
`else
    lz_blank     = 1'b0;
`endif
    // Registered so the enable lines up with the ROM's one-cycle read latency.
    an_d         = lz_blank ? 4'b1111 : ~(4'b0001 << digit_q);
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tick_cnt_q   <= 16'd0;
      digit_q      <= 2'd0;
      shadow_q     <= 16'd0;
      pending_q    <= 16'd0;
      pend_valid_q <= 1'b0;
      loaded_q     <= 1'b0;
      an_q         <= 4'b1111;
    end else begin
      tick_cnt_q   <= tick_cnt_d;
      digit_q      <= digit_d;
      shadow_q     <= shadow_d;
      pending_q    <= pending_d;
      pend_valid_q <= pend_valid_d;
      loaded_q     <= loaded_d;
      an_q         <= an_d;
    end
  end
  assign loaded = loaded_q;
  assign an     = an_q;
  assign seg    = rom_data;
endmodule

// File: tb/tb_seg_scan_ctrl.sv
// tb_seg_scan_ctrl: self-checking bench for seg_scan_ctrl (CLK_DIV=4) with a cycle-count reference model
module tb_seg_scan_ctrl;
  localparam int D = 4;
  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [15:0] value = 16'd0;
  logic        load = 1'b0;
  logic        loaded;
  logic [3:0]  rom_addr;
  logic [6:0]  rom_data = 7'd0;
  logic [6:0]  seg;
  logic [3:0]  an;
  int n_chk = 0, n_fail = 0, pulses = 0;
  int n;
  logic [15:0] m_shadow, m_pend;
  bit m_pv, m_loaded;
  seg_scan_ctrl #(.CLK_DIV(D)) dut (
    .clk(clk), .reset(reset), .value(value), .load(load), .loaded(loaded),
    .rom_addr(rom_addr), .rom_data(rom_data), .seg(seg), .an(an)
  );
  always #5 clk = ~clk;
  function automatic logic [6:0] rom_pat(input logic [3:0] a);
    return 7'(int'(a) * 7 + 3);
  endfunction
  always @(posedge clk) rom_data <= rom_pat(rom_addr);
  function automatic logic [3:0] nib(input logic [15:0] s, input int d);
    return s[4*d +: 4];
  endfunction
  function automatic logic [3:0] exp_an(input int d, input logic [15:0] s);
    logic [3:0] r;
    r = ~(4'b0001 << d);
`ifdef SEG_SCAN_LZ_BLANK_EN
    if (d != 0 && (s >> (4 * d)) == 16'd0) r = 4'b1111;
`endif
    return r;
  endfunction
  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %h, expected %h", name, n, act, exp);
    end
  endtask
  // One clock: drive inputs, advance the model by the rules, then check all outputs.
  task automatic step(input bit ld, input logic [15:0] v);
    bit fs;
    int pd;
    logic [15:0] ps;
    load = ld;
    value = v;
    @(posedge clk);
    fs = (n % (4 * D)) == 4 * D - 1;
    pd = (n / D) % 4;
    ps = m_shadow;
    if (fs) begin
      m_loaded = ld || m_pv;
      if (ld) m_shadow = v;
      else if (m_pv) m_shadow = m_pend;
      m_pv = 0;
    end else begin
      m_loaded = 0;
      if (ld) begin
        m_pend = v;
        m_pv = 1;
      end
    end
    n++;
    #1;
    load = 1'b0;
    chk("an", 16'(an), 16'(exp_an(pd, ps)));
    chk("seg", 16'(seg), 16'(rom_pat(nib(ps, pd))));
    chk("rom_addr", 16'(rom_addr), 16'(nib(m_shadow, (n / D) % 4)));
    chk("loaded", 16'(loaded), 16'(m_loaded));
    if (loaded) pulses++;
  endtask
  task automatic run_to(input int t);
    while (n < t) step(1'b0, 16'($urandom));
  endtask
  task automatic do_reset();
    reset = 1'b0;
    #1;
    reset = 1'b1;
    #1;
    chk("rst_an", 16'(an), 16'hF);
    chk("rst_loaded", 16'(loaded), 16'h0);
    chk("rst_rom_addr", 16'(rom_addr), 16'h0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    n = 0;
    m_shadow = 16'd0;
    m_pend = 16'd0;
    m_pv = 0;
    m_loaded = 0;
    pulses = 0;
  endtask
  typedef struct {
    int cyc;
    logic [3:0] an;
    logic [3:0] addr;
  } vec_t;
  vec_t tbl[6];
  initial begin
    tbl[0] = '{1, 4'b1110, 4'h0};
    tbl[1] = '{4, 4'b1110, 4'h0};
    tbl[2] = '{5, 4'b1101, 4'h0};
    tbl[3] = '{9, 4'b1011, 4'h0};
    tbl[4] = '{13, 4'b0111, 4'h0};
    tbl[5] = '{17, 4'b1110, 4'h0};
    n = 0;
    do_reset();
`ifndef SEG_SCAN_LZ_BLANK_EN
    for (int i = 0; i < 6; i++) begin
      run_to(tbl[i].cyc);
      chk("scan_an", 16'(an), 16'(tbl[i].an));
      chk("scan_addr", 16'(rom_addr), 16'(tbl[i].addr));
    end
`endif
    // mid-frame load is held until the next frame start
    do_reset();
    run_to(5);
    step(1'b1, 16'h1234);
    run_to(14);
    chk("hold_addr", 16'(rom_addr), 16'h0);
    chk("hold_pulses", 16'(pulses), 16'h0);
    run_to(17); chk("seq_d0", 16'(rom_addr), 16'h4);
    run_to(21); chk("seq_d1", 16'(rom_addr), 16'h3);
    run_to(25); chk("seq_d2", 16'(rom_addr), 16'h2);
    run_to(29); chk("seq_d3", 16'(rom_addr), 16'h1);
    run_to(40); chk("one_pulse_1234", 16'(pulses), 16'h1);
    // second load in the same frame overwrites the first
    do_reset();
    run_to(3);
    step(1'b1, 16'hAAAA);
    run_to(8);
    step(1'b1, 16'h5555);
    run_to(17); chk("ovr_addr", 16'(rom_addr), 16'h5);
    run_to(40); chk("ovr_addr2", 16'(rom_addr), 16'h5);
    chk("ovr_pulses", 16'(pulses), 16'h1);
    // load exactly on the frame-start tick commits immediately
    do_reset();
    run_to(15);
    step(1'b1, 16'hBEEF);
    chk("fs_loaded", 16'(loaded), 16'h1);
    chk("fs_addr", 16'(rom_addr), 16'hF);
    run_to(40); chk("fs_pulses", 16'(pulses), 16'h1);
    // reset with a pending load discards it
    do_reset();
    run_to(4);
    step(1'b1, 16'h1234);
    do_reset();
    run_to(40);
    chk("rst_pend_pulses", 16'(pulses), 16'h0);
    chk("rst_pend_addr", 16'(rom_addr), 16'h0);
`ifdef SEG_SCAN_LZ_BLANK_EN
    do_reset();
    run_to(2); chk("lz_zero_d0", 16'(an), 16'hE);
    run_to(6); chk("lz_zero_d1", 16'(an), 16'hF);
    run_to(15);
    step(1'b1, 16'h0042);
    run_to(18); chk("lz_d0", 16'(an), 16'hE);
    run_to(22); chk("lz_d1", 16'(an), 16'hD);
    run_to(26); chk("lz_d2", 16'(an), 16'hF);
    run_to(30); chk("lz_d3", 16'(an), 16'hF);
`endif
    // randomized loads checked every cycle by the model
    do_reset();
    for (int i = 0; i < 400; i++) step($urandom_range(0, 5) == 0, 16'($urandom));
    run_to(n + 4 * D);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/seg_scan_ctrl.md
SEG_SCAN_CTRL -- requirements
Module: seg_scan_ctrl

Interface
REQ-001 SHALL have parameter CLK_DIV, default 50000: clk cycles per digit slot; legal range 2..65535.
REQ-002 SHALL have port clk, input, 1: sole clock; all state updates on rising edge.
REQ-003 SHALL have port reset, input, 1: asynchronous, active-high reset.
REQ-004 SHALL have port value, input, 16: four hex nibbles to display; digit k uses value[4k+3:4k].
REQ-005 SHALL have port load, input, 1: single-cycle request to capture value.
REQ-006 SHALL have port loaded, output, 1: one-cycle pulse when the captured value is committed to the display.
REQ-007 SHALL have port rom_addr, output, 4: address to the downstream synchronous pattern ROM.
REQ-008 SHALL have port rom_data, input, 7: ROM pattern, valid one clk after rom_addr.
REQ-009 SHALL have port seg, output, 7: segment drive; equals rom_data with no added delay.
REQ-010 SHALL have port an, output, 4: active-low digit enables; one-hot-low when a digit is lit.

Function
REQ-011 SHALL count tick_cnt 0..CLK_DIV-1 and wrap; a tick is the cycle tick_cnt equals CLK_DIV-1.
REQ-012 SHALL advance digit_idx (2 bits) on each tick, 0->1->2->3->0.
REQ-013 SHALL drive rom_addr combinationally as nibble digit_idx of the shadow register.
REQ-014 SHALL register an from digit_idx, so an changes one clk after digit_idx, aligned with rom_data.
REQ-015 SHALL drive an[k]=0 only for k equal to the delayed digit_idx; all other bits 1.
REQ-016 SHALL, on load, copy value into pending and set pend_valid; a later load before commit overwrites pending.
REQ-017 SHALL commit at frame start (the tick where digit_idx wraps 3->0): if pend_valid, shadow<=pending, pend_valid<=0, loaded pulses on the following cycle.
REQ-018 SHALL, when load coincides with a frame-start tick, commit value directly to shadow that edge, leave pend_valid 0, and pulse loaded.
REQ-019 SHALL never change shadow outside a frame-start tick (no tearing within a frame).
REQ-020 SHALL keep loaded 0 on every cycle without a commit.

Reset
REQ-021 SHALL, while reset is high, force tick_cnt=0, digit_idx=0, shadow=0, pending=0, pend_valid=0, loaded=0, an=4'b1111.
REQ-022 SHALL drive an=4'b1110 on the first clk edge after reset deasserts.
REQ-023 SHALL discard a pending load when reset asserts mid-frame; no loaded pulse results.

Configuration
REQ-024 SHALL, with SEG_SCAN_LZ_BLANK_EN defined, force an to 4'b1111 for any digit k>0 when all nibbles k..3 of shadow are zero; digit 0 is never blanked.
REQ-025 SHALL, without SEG_SCAN_LZ_BLANK_EN, light every digit in turn regardless of value.

Verification
REQ-026 SHALL cover: CLK_DIV=4, reset release -> an=1110 at edge 1, rom_addr=0, an steps 1101,1011,0111 every 4 clks, wraps to 1110.
REQ-027 SHALL cover: load value=16'h1234 mid-frame -> shadow unchanged until frame start, then rom_addr sequence 4,3,2,1, loaded pulses exactly once.
REQ-028 SHALL cover: load 16'hAAAA then 16'h5555 in same frame -> only 16'h5555 displayed, one loaded pulse.
REQ-029 SHALL cover: load 16'hBEEF on the frame-start tick -> committed that edge, rom_addr=F in next slot, loaded next cycle.
REQ-030 SHALL cover: SEG_SCAN_LZ_BLANK_EN, shadow=16'h0042 -> digits 2,3 slots show an=1111; digit 0 with shadow=0 still lit.
REQ-031 SHALL cover: reset asserted with pend_valid=1 -> outputs per REQ-021 immediately, no loaded pulse after release.
